// File: rtl/riscv_types_pkg.sv
// Shared RISC-V execute-stage types: ALU opcodes plus the divider FSM state and iteration count.
package riscv_types;

  typedef enum logic [4:0] {
    ALU_ADD = 5'd0,
    ALU_SUB,
    ALU_SLL,
    ALU_SLT,
    ALU_SLTU,
    ALU_XOR,
    ALU_SRL,
    ALU_SRA,
    ALU_OR,
    ALU_AND,
    ALU_LUI,
    ALU_MUL,
    ALU_MULH,
    ALU_MULHSU,
    ALU_MULHU,
    ALU_DIV,
    ALU_DIVU,
    ALU_REM,
    ALU_REMU
  } alu_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } div_state_t;

  localparam int DIV_ITERATIONS = 32;

  function automatic logic is_div_op(input alu_t op);
    return (op == ALU_DIV) || (op == ALU_DIVU) || (op == ALU_REM) || (op == ALU_REMU);
  endfunction

endpackage

// File: rtl/riscv_div_unit_div_step.sv
// One combinational restoring radix-2 division step on the remainder/quotient pair.
module div_step #(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] i_rem,
  input  logic [XLEN-1:0] i_quot,
  input  logic [XLEN-1:0] i_divisor,
  output logic [XLEN-1:0] o_rem,
  output logic [XLEN-1:0] o_quot
);

  logic [XLEN:0]   w_shift;
  logic            w_borrow;
  logic [XLEN-1:0] w_diff;

  assign w_shift  = {i_rem, i_quot[XLEN-1]};
  assign w_borrow = w_shift < {1'b0, i_divisor};
  // Without a borrow the true difference is below the divisor, so the low XLEN bits are exact.
  assign w_diff   = w_shift[XLEN-1:0] - i_divisor;

  assign o_rem  = w_borrow ? w_shift[XLEN-1:0] : w_diff;
  assign o_quot = {i_quot[XLEN-2:0], ~w_borrow};

endmodule

// File: rtl/riscv_div_unit.sv
// Iterative 32-cycle RV32M divider (DIV/DIVU/REM/REMU) with valid/ready request and response.
// Define DIV_FAST_SPECIAL_EN to complete divide-by-zero and signed overflow on the acceptance edge.
module riscv_div_unit
  import riscv_types::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            req_valid_i,
  output logic            req_ready_o,
  input  alu_t            op_i,
  input  logic [XLEN-1:0] rs1_i,
  input  logic [XLEN-1:0] rs2_i,
  input  logic            flush_i,
  output logic            resp_valid_o,
  input  logic            resp_ready_i,
  output logic [XLEN-1:0] result_o,
  output logic            busy_o
);

  localparam logic [4:0]      LAST_ITER = 5'(DIV_ITERATIONS - 1);
  localparam logic [XLEN-1:0] MOST_NEG  = {1'b1, {(XLEN-1){1'b0}}};

  div_state_t      r_state;
  alu_t            r_op;
  logic [XLEN-1:0] r_rs1;
  logic [XLEN-1:0] r_divisor;
  logic [XLEN-1:0] r_rem;
  logic [XLEN-1:0] r_quot;
  logic            r_q_neg;
  logic            r_r_neg;
  logic            r_div_zero;
  logic            r_overflow;
  logic [4:0]      r_cnt;

  logic            w_signed;
  logic            w_accept;
  logic            w_div_zero;
  logic            w_overflow;
  logic            w_is_quot;
  logic [XLEN-1:0] w_rs1_mag;
  logic [XLEN-1:0] w_rs2_mag;
  logic [XLEN-1:0] w_rem_next;
  logic [XLEN-1:0] w_quot_next;
  logic [XLEN-1:0] w_quot_s;
  logic [XLEN-1:0] w_rem_s;
  logic [XLEN-1:0] w_result;

  assign w_signed    = (op_i == ALU_DIV) || (op_i == ALU_REM);
  assign req_ready_o = reset_n & (r_state == IDLE) & ~flush_i & is_div_op(op_i);
  assign w_accept    = req_valid_i & req_ready_o;
  assign w_div_zero  = (rs2_i == '0);
  assign w_overflow  = w_signed & (rs1_i == MOST_NEG) & (rs2_i == '1);
  assign w_rs1_mag   = (w_signed & rs1_i[XLEN-1]) ? -rs1_i : rs1_i;
  assign w_rs2_mag   = (w_signed & rs2_i[XLEN-1]) ? -rs2_i : rs2_i;

  div_step #(.XLEN(XLEN)) u_div_step (
    .i_rem     (r_rem),
    .i_quot    (r_quot),
    .i_divisor (r_divisor),
    .o_rem     (w_rem_next),
    .o_quot    (w_quot_next)
  );

  // Flush acts as a synchronous clear and outranks both acceptance and the response handshake.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= IDLE;
    end else if (flush_i) begin
      r_state <= IDLE;
    end else begin
      case (r_state)
`ifdef DIV_FAST_SPECIAL_EN
        IDLE:    if (w_accept) r_state <= (w_div_zero | w_overflow) ? DONE : CALC;
`else
        IDLE:    if (w_accept) r_state <= CALC;
`endif
        CALC:    if (r_cnt == LAST_ITER) r_state <= DONE;
        DONE:    if (resp_ready_i) r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_op       <= ALU_ADD;
      r_rs1      <= '0;
      r_divisor  <= '0;
      r_rem      <= '0;
      r_quot     <= '0;
      r_q_neg    <= 1'b0;
      r_r_neg    <= 1'b0;
      r_div_zero <= 1'b0;
      r_overflow <= 1'b0;
      r_cnt      <= '0;
    end else if (w_accept) begin
      r_op       <= op_i;
      r_rs1      <= rs1_i;
      r_divisor  <= w_rs2_mag;
      r_rem      <= '0;
      r_quot     <= w_rs1_mag;
      r_q_neg    <= w_signed & (rs1_i[XLEN-1] ^ rs2_i[XLEN-1]);
      r_r_neg    <= w_signed & rs1_i[XLEN-1];
      r_div_zero <= w_div_zero;
      r_overflow <= w_overflow;
      r_cnt      <= '0;
    end else if (r_state == CALC) begin
      r_rem  <= w_rem_next;
      r_quot <= w_quot_next;
      r_cnt  <= r_cnt + 5'd1;
    end
  end

  assign w_is_quot = (r_op == ALU_DIV) || (r_op == ALU_DIVU);
  assign w_quot_s  = r_q_neg ? -r_quot : r_quot;
  assign w_rem_s   = r_r_neg ? -r_rem : r_rem;

  // Special cases override whatever the iteration produced.
  always_comb begin
    w_result = w_is_quot ? w_quot_s : w_rem_s;
    if (r_div_zero) begin
      w_result = w_is_quot ? '1 : r_rs1;
    end else if (r_overflow) begin
      w_result = w_is_quot ? MOST_NEG : '0;
    end
  end

  assign resp_valid_o = (r_state == DONE);
  assign result_o     = resp_valid_o ? w_result : '0;
  assign busy_o       = (r_state != IDLE);

endmodule

// File: doc/riscv_div_unit.md
RISCV_DIV_UNIT -- requirements
Module: riscv_div_unit

Interface
REQ-001 Parameter: XLEN, default 32, operand and result width; only 32 is supported.
REQ-002 clk  input  1  rising-edge clock.
REQ-003 reset_n  input  1  asynchronous, active-low reset.
REQ-004 req_valid_i  input  1  EX stage presents a divide request.
REQ-005 req_ready_o  output  1  unit accepts the request this cycle.
REQ-006 op_i  input  5  riscv_types::alu_t opcode; only DIV, DIVU, REM and REMU are meaningful.
REQ-007 rs1_i  input  XLEN  dividend.
REQ-008 rs2_i  input  XLEN  divisor.
REQ-009 flush_i  input  1  pipeline flush; abandons any in-flight operation.
REQ-010 resp_valid_o  output  1  result available.
REQ-011 resp_ready_i  input  1  consumer takes the result.
REQ-012 result_o  output  XLEN  quotient or remainder; defined only while resp_valid_o is 1.
REQ-013 busy_o  output  1  high in any state other than IDLE.

Function
REQ-014 The state machine SHALL have exactly three states:
- IDLE: waiting for a request.
- CALC: iterating.
- DONE: holding the result.
REQ-015 req_ready_o SHALL equal (state==IDLE) & ~flush_i & (op_i is one of DIV, DIVU, REM, REMU).
REQ-016 Acceptance SHALL occur at a rising edge where req_valid_i & req_ready_o; that edge latches the operands, the opcode, the operand magnitudes, the result sign and the special-case flags, clears the 5-bit iteration counter and enters CALC.
REQ-017 Signed ops (DIV, REM) SHALL divide magnitudes; the quotient sign SHALL be sign(rs1) XOR sign(rs2); the remainder sign SHALL be sign(rs1).
REQ-018 Each CALC edge SHALL perform one restoring radix-2 step (shift the remainder/quotient pair, trial-subtract the divisor, restore on borrow) and increment the counter.
REQ-019 After the 32nd CALC edge the unit SHALL enter DONE, so resp_valid_o rises 32 cycles after the acceptance edge.
REQ-020 result_o SHALL be the sign-corrected quotient for DIV/DIVU and the sign-corrected remainder for REM/REMU, formed combinationally from the registered state.
REQ-021 Division by zero SHALL return:
- DIV/DIVU: 0xFFFFFFFF.
- REM/REMU: rs1.
REQ-022 DIV with rs1=0x80000000 and rs2=0xFFFFFFFF SHALL return 0x80000000; REM with the same operands SHALL return 0.
REQ-023 DONE SHALL hold resp_valid_o and result_o stable until resp_ready_i=1; the handshake edge returns the unit to IDLE.
REQ-024 No new request SHALL be accepted on the same edge as the response handshake; back-to-back throughput is one operation per 34 cycles minimum.
REQ-025 flush_i=1 at an edge in any state SHALL force IDLE with no response. Flush takes priority over acceptance and over the response handshake.
REQ-026 Opcodes outside the four divide ops SHALL never be accepted and SHALL leave all state unchanged.

Reset
REQ-027 reset_n low SHALL immediately set the state to IDLE and clear the counter, the operand registers and the result registers. While reset is low: req_ready_o=0, resp_valid_o=0, busy_o=0, result_o=0.
REQ-028 A reset asserted during CALC or DONE SHALL discard the operation; no response SHALL follow the deassertion of reset.

Configuration
REQ-029 Macro DIV_FAST_SPECIAL_EN:
- Defined: divide-by-zero and signed-overflow requests SHALL go from IDLE directly to DONE on the acceptance edge, so resp_valid_o is high one cycle after acceptance, with the REQ-021/022 values.
- Undefined: these requests SHALL take the full 32-cycle latency, with the same values forced at the output.

Structure
REQ-030 Package riscv_types SHALL gain:
- enum div_state_t {IDLE, CALC, DONE}.
- constant DIV_ITERATIONS=32.
REQ-031 One sub-module, div_step, SHALL implement the combinational single restoring iteration: inputs remainder, quotient and divisor; outputs next remainder and next quotient.
REQ-032 Registers MAY use n_bit_reg/n_bit_reg_wclr; the state register SHALL use flush as its synchronous clear.

Verification
REQ-033 DIVU 100/7 -> result 14 exactly 32 cycles after acceptance; REMU 100/7 -> 2.
REQ-034 DIV -7/2 -> 0xFFFFFFFD (-3); REM -7/2 -> 0xFFFFFFFF (-1); REM 7/-2 -> 1.
REQ-035 DIV 5/0 -> 0xFFFFFFFF; REM 5/0 -> 5; DIV 0x80000000/0xFFFFFFFF -> 0x80000000. Latency is 1 cycle with DIV_FAST_SPECIAL_EN defined and 32 cycles without.
REQ-036 DIVU 9/3 with resp_ready_i held low for 10 cycles -> resp_valid_o and result 3 stable throughout; the handshake returns to IDLE and req_ready_o rises the next cycle.
REQ-037 Flush at CALC iteration 10 -> IDLE next cycle, no response ever; a following DIVU 8/2 -> 4.
REQ-038 reset_n pulsed low during DONE -> all outputs 0 immediately, no stale response after release; op_i=ADD with req_valid_i=1 -> req_ready_o=0 and state stays IDLE.
